// File: rtl/ecc_sched_pkg.sv
// Shared types and constants for the two-requester ECC decode scheduler.
// Response entries carry a fixed-width tag field; the top uses the low TAG_W bits.
package ecc_sched_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int DEC_LAT    = 1;
  localparam int TAG_MAX_W  = 32;

  typedef struct packed {
    logic                 id;
    logic [TAG_MAX_W-1:0] tag;
    logic [63:0]          data;
    logic                 corr;
    logic                 fatal;
  } rsp_ent_t;

endpackage

// File: rtl/ecc_rr_arb2.sv
// Two-way round-robin arbiter: one grant per cycle, the pointer moves only on a grant.
// After reset requester A wins the first tie.
module ecc_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // last_q = 1 means B was granted most recently, so A has priority on a tie
  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt[0])      last_d = 1'b0;
    else if (gnt[1]) last_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/ecc_dec_sched.sv
// Schedules two requesters onto a shared latency-1 ECC decoder and queues the results
// in a 2-entry response FIFO with credit-based admission and error counters.
module ecc_dec_sched
  import ecc_sched_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [71:0]      req_cw_a,
  input  logic [71:0]      req_cw_b,
  input  logic [TAG_W-1:0] req_tag_a,
  input  logic [TAG_W-1:0] req_tag_b,
  output logic [71:0]      dec_data,
  input  logic [63:0]      dec_q,
  input  logic             dec_corr,
  input  logic             dec_det,
  input  logic             dec_fatal,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [63:0]      rsp_data,
  output logic             rsp_corr,
  output logic             rsp_fatal,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] fatal_cnt,
  output logic             fatal_irq,
  input  logic             cnt_clr
);

  logic [1:0]       gnt;
  logic             credit_ok;

  logic             infl_vld_q, infl_vld_d;
  logic             infl_id_q, infl_id_d;
  logic [TAG_W-1:0] infl_tag_q, infl_tag_d;
  rsp_ent_t         infl_ent;

  rsp_ent_t         fifo_q [FIFO_DEPTH];
  rsp_ent_t         fifo_d [FIFO_DEPTH];
  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;

  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] fatal_cnt_q, fatal_cnt_d;
  logic             fatal_irq_q, fatal_irq_d;

  rsp_ent_t         head;
  logic             fifo_empty, pop, bypass, fifo_wr, fifo_rd;

  assign credit_ok = ({1'b0, occ_q} + {2'b00, infl_vld_q}) < 3'd2;

  ecc_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (reset_n),
    .req   (req_valid),
    .en    (credit_ok),
    .gnt   (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    dec_data = '0;
    if (gnt[0])      dec_data = req_cw_a;
    else if (gnt[1]) dec_data = req_cw_b;
  end

  always_comb begin
    infl_vld_d = |gnt;
    infl_id_d  = infl_id_q;
    infl_tag_d = infl_tag_q;
    if (gnt[0]) begin
      infl_id_d  = 1'b0;
      infl_tag_d = req_tag_a;
    end else if (gnt[1]) begin
      infl_id_d  = 1'b1;
      infl_tag_d = req_tag_b;
    end
  end

  // Decoder results land this cycle; the entry is assembled straight from them
  always_comb begin
    infl_ent                = '0;
    infl_ent.id             = infl_id_q;
    infl_ent.tag[TAG_W-1:0] = infl_tag_q;
    infl_ent.data           = dec_q;
    infl_ent.corr           = dec_corr;
    infl_ent.fatal          = dec_fatal | (dec_det & ~dec_corr);
  end

  // An empty FIFO lets the in-flight result show on rsp_* in its own cycle
  assign fifo_empty = (occ_q == 2'd0);
  assign head       = fifo_empty ? infl_ent : fifo_q[rd_ptr_q];
  assign rsp_valid  = ~fifo_empty | infl_vld_q;
  assign pop        = rsp_valid & rsp_ready;
  assign bypass     = infl_vld_q & fifo_empty & rsp_ready;
  assign fifo_wr    = infl_vld_q & ~bypass;
  assign fifo_rd    = pop & ~fifo_empty;

  assign rsp_id    = rsp_valid & head.id;
  assign rsp_tag   = rsp_valid ? head.tag[TAG_W-1:0] : '0;
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_corr  = rsp_valid & head.corr;
  assign rsp_fatal = rsp_valid & head.fatal;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (fifo_wr) begin
      fifo_d[wr_ptr_q] = infl_ent;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (fifo_rd) rd_ptr_d = ~rd_ptr_q;
    case ({fifo_wr, fifo_rd})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Every completed decode counts, whether it went into the FIFO or straight out
  always_comb begin
    corr_cnt_d  = corr_cnt_q;
    fatal_cnt_d = fatal_cnt_q;
    fatal_irq_d = fatal_irq_q;
    if (cnt_clr) begin
      corr_cnt_d  = '0;
      fatal_cnt_d = '0;
      fatal_irq_d = 1'b0;
    end else if (infl_vld_q) begin
      if (infl_ent.corr && (corr_cnt_q != '1))   corr_cnt_d  = corr_cnt_q + 1'b1;
      if (infl_ent.fatal && (fatal_cnt_q != '1)) fatal_cnt_d = fatal_cnt_q + 1'b1;
      if (infl_ent.fatal)                        fatal_irq_d = 1'b1;
    end
  end

  assign corr_cnt  = corr_cnt_q;
  assign fatal_cnt = fatal_cnt_q;
  assign fatal_irq = fatal_irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      infl_vld_q  <= 1'b0;
      infl_id_q   <= 1'b0;
      infl_tag_q  <= '0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      corr_cnt_q  <= '0;
      fatal_cnt_q <= '0;
      fatal_irq_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      infl_vld_q  <= infl_vld_d;
      infl_id_q   <= infl_id_d;
      infl_tag_q  <= infl_tag_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      corr_cnt_q  <= corr_cnt_d;
      fatal_cnt_q <= fatal_cnt_d;
      fatal_irq_q <= fatal_irq_d;
      fifo_q      <= fifo_d;
    end
  end

endmodule

// File: tb/tb_ecc_dec_sched.sv
// Bench for ecc_dec_sched: directed scenarios plus random traffic against a queue-based model.
// A stub decoder treats codeword bits 64/65/66 as corrected/detected/fatal flags.
module tb_ecc_dec_sched;

  localparam int RW = 75;  // {id, tag[7:0], data[63:0], corr, fatal}

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready, req_ready4;
  logic [71:0] req_cw_a = '0, req_cw_b = '0;
  logic [7:0]  req_tag_a = '0, req_tag_b = '0;
  logic [71:0] dec_data, dec_data4;
  logic [63:0] dec_q = '0, dec_q4 = '0;
  logic        dec_corr = 1'b0, dec_det = 1'b0, dec_fatal = 1'b0;
  logic        dec_corr4 = 1'b0, dec_det4 = 1'b0, dec_fatal4 = 1'b0;
  logic        rsp_valid, rsp_valid4;
  logic        rsp_ready = 1'b0;
  logic        rsp_id, rsp_id4;
  logic [7:0]  rsp_tag, rsp_tag4;
  logic [63:0] rsp_data, rsp_data4;
  logic        rsp_corr, rsp_corr4, rsp_fatal, rsp_fatal4;
  logic [15:0] corr_cnt, fatal_cnt;
  logic [3:0]  corr_cnt4, fatal_cnt4;
  logic        fatal_irq, fatal_irq4;
  logic        cnt_clr = 1'b0;

  ecc_dec_sched #(.TAG_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cw_a(req_cw_a), .req_cw_b(req_cw_b), .req_tag_a(req_tag_a), .req_tag_b(req_tag_b),
    .dec_data(dec_data), .dec_q(dec_q), .dec_corr(dec_corr), .dec_det(dec_det),
    .dec_fatal(dec_fatal), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_corr(rsp_corr), .rsp_fatal(rsp_fatal),
    .corr_cnt(corr_cnt), .fatal_cnt(fatal_cnt), .fatal_irq(fatal_irq), .cnt_clr(cnt_clr)
  );

  ecc_dec_sched #(.TAG_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready4),
    .req_cw_a(req_cw_a), .req_cw_b(req_cw_b), .req_tag_a(req_tag_a), .req_tag_b(req_tag_b),
    .dec_data(dec_data4), .dec_q(dec_q4), .dec_corr(dec_corr4), .dec_det(dec_det4),
    .dec_fatal(dec_fatal4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_id(rsp_id4),
    .rsp_tag(rsp_tag4), .rsp_data(rsp_data4), .rsp_corr(rsp_corr4), .rsp_fatal(rsp_fatal4),
    .corr_cnt(corr_cnt4), .fatal_cnt(fatal_cnt4), .fatal_irq(fatal_irq4), .cnt_clr(cnt_clr)
  );

  // Clock and stub decoders (one-cycle latency)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    dec_q      <= dec_data[63:0];
    dec_corr   <= dec_data[64];
    dec_det    <= dec_data[65];
    dec_fatal  <= dec_data[66];
    dec_q4     <= dec_data4[63:0];
    dec_corr4  <= dec_data4[64];
    dec_det4   <= dec_data4[65];
    dec_fatal4 <= dec_data4[66];
  end

  // Scoreboard and reference model state
  int n_pass = 0;
  int n_chk  = 0;
  logic [RW-1:0] exp_q[$];
  int  last_g  = 1;   // requester granted most recently; 1 lets A win the first tie
  bit  infl_v  = 0;
  bit  infl_c  = 0;
  bit  infl_f  = 0;
  int  corr_m  = 0, fatal_m = 0, corr4_m = 0, fatal4_m = 0;
  bit  irq_m   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [71:0] mk_cw(input logic [2:0] fl);
    logic [71:0] c;
    c[31:0]  = $urandom;
    c[63:32] = $urandom;
    c[66:64] = fl;
    c[71:67] = 5'($urandom_range(0, 31));
    return c;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_g = 1; infl_v = 0; infl_c = 0; infl_f = 0;
    corr_m = 0; fatal_m = 0; corr4_m = 0; fatal4_m = 0; irq_m = 0;
  endtask

  // One clock: entered just after a falling edge with inputs already set
  task automatic step();
    logic [1:0]    g;
    logic [71:0]   cw;
    logic [RW-1:0] hd;
    logic [7:0]    tg;
    bit            pop, c, f, clr;
    #1;
    g = 2'b00;
    if (exp_q.size() < 2) begin
      if (req_valid == 2'b11) g = (last_g == 0) ? 2'b10 : 2'b01;
      else                    g = req_valid;
    end
    cw = g[0] ? req_cw_a : (g[1] ? req_cw_b : 72'd0);
    chk("req_ready", req_ready, g);
    chk("req_ready_w4", req_ready4, g);
    chk("dec_data", dec_data, cw);
    chk("rsp_valid", rsp_valid, exp_q.size() > 0);
    chk("rsp_valid_w4", rsp_valid4, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      hd = exp_q[0];
      chk("rsp_id", rsp_id, hd[74]);
      chk("rsp_tag", rsp_tag, hd[73:66]);
      chk("rsp_data", rsp_data, hd[65:2]);
      chk("rsp_corr", rsp_corr, hd[1]);
      chk("rsp_fatal", rsp_fatal, hd[0]);
    end
    chk("corr_cnt", corr_cnt, corr_m);
    chk("fatal_cnt", fatal_cnt, fatal_m);
    chk("fatal_irq", fatal_irq, irq_m);
    chk("corr_cnt_w4", corr_cnt4, corr4_m);
    chk("fatal_cnt_w4", fatal_cnt4, fatal4_m);
    pop = (exp_q.size() > 0) && rsp_ready;
    clr = cnt_clr;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (clr) begin
      corr_m = 0; fatal_m = 0; corr4_m = 0; fatal4_m = 0; irq_m = 0;
    end else if (infl_v) begin
      if (infl_c && corr_m < 65535) corr_m++;
      if (infl_f && fatal_m < 65535) fatal_m++;
      if (infl_c && corr4_m < 15) corr4_m++;
      if (infl_f && fatal4_m < 15) fatal4_m++;
      if (infl_f) irq_m = 1;
    end
    infl_v = (g != 2'b00);
    if (infl_v) begin
      c  = cw[64];
      f  = cw[66] | (cw[65] & ~cw[64]);
      tg = g[0] ? req_tag_a : req_tag_b;
      exp_q.push_back({g[1], tg, cw[63:0], c, f});
      infl_c = c;
      infl_f = f;
      last_g = g[0] ? 0 : 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 2'b00;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_dec_data", dec_data, 72'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_corr_cnt", corr_cnt, 16'd0);
    chk("rst_fatal_irq", fatal_irq, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Single A request, clean codeword, tag 0x5A
    rsp_ready = 1'b1;
    req_valid = 2'b01; req_tag_a = 8'h5A; req_cw_a = mk_cw(3'b000);
    step();
    req_valid = 2'b00;
    #1;
    chk("t_single_valid", rsp_valid, 1'b1);
    chk("t_single_id", rsp_id, 1'b0);
    chk("t_single_tag", rsp_tag, 8'h5A);
    chk("t_single_corr", rsp_corr, 1'b0);
    chk("t_single_fatal", rsp_fatal, 1'b0);
    step();
    idle(1);

    // Both valid, ready downstream: strict A/B alternation
    for (int i = 0; i < 6; i++) begin
      req_valid = 2'b11;
      req_tag_a = 8'($urandom); req_tag_b = 8'($urandom);
      req_cw_a  = mk_cw(3'b000); req_cw_b = mk_cw(3'b000);
      step();
    end
    idle(2);

    // Backpressure: two grants fill the credit, then drain in order
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 2'b11;
      req_tag_a = 8'($urandom); req_tag_b = 8'($urandom);
      req_cw_a  = mk_cw(3'($urandom_range(0, 7))); req_cw_b = mk_cw(3'($urandom_range(0, 7)));
      step();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    idle(3);

    // Error counting and clear
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b01;
      req_tag_a = 8'(i);
      req_cw_a  = mk_cw((i < 3) ? 3'b001 : 3'b010);
      step();
    end
    idle(2);
    chk("t_err_corr", corr_cnt, 16'd3);
    chk("t_err_fatal", fatal_cnt, 16'd1);
    chk("t_err_irq", fatal_irq, 1'b1);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    #1;
    chk("t_clr_corr", corr_cnt, 16'd0);
    chk("t_clr_fatal", fatal_cnt, 16'd0);
    chk("t_clr_irq", fatal_irq, 1'b0);
    @(negedge clk);

    // Saturation of the 4-bit counters
    for (int i = 0; i < 17; i++) begin
      req_valid = 2'b01;
      req_tag_a = 8'($urandom);
      req_cw_a  = mk_cw(3'b001);
      step();
    end
    idle(2);
    chk("t_sat_w4", corr_cnt4, 4'd15);
    chk("t_sat_w16", corr_cnt, 16'd17);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_tag_a = 8'($urandom); req_tag_b = 8'($urandom);
      req_cw_a  = mk_cw(3'($urandom_range(0, 7)));
      req_cw_b  = mk_cw(3'($urandom_range(0, 7)));
      rsp_ready = ($urandom_range(0, 9) < 7);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      step();
    end
    cnt_clr = 1'b0;
    rsp_ready = 1'b1;
    idle(3);

    // Reset with one response queued and one in flight
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    req_cw_a  = mk_cw(3'b001); req_cw_b = mk_cw(3'b100);
    step();
    step();
    req_valid = 2'b00;
    reset_n   = 1'b0;
    #1;
    chk("t_rst_rsp_valid", rsp_valid, 1'b0);
    chk("t_rst_corr_cnt", corr_cnt, 16'd0);
    chk("t_rst_fatal_cnt", fatal_cnt, 16'd0);
    chk("t_rst_irq", fatal_irq, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    idle(4);
    req_valid = 2'b10; req_tag_b = 8'hC3; req_cw_b = mk_cw(3'b000);
    step();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
